// File: rtl/linear_layer_requant_q.sv
// -----------------------------------------------------------------------------
// linear_layer_requant_q
//
// Requantizes signed MAC accumulator values to a narrow signed output:
//   S1: product = acc (signed) * scale (unsigned), effective shift clamped
//   S2: round-half-up arithmetic right shift by the per-beat shift amount
//   S3: saturate to the output range, registered outputs
// All three stages advance together on adv = ce & (~out_valid | out_ready),
// so a stalled output freezes the whole pipe and beats are never dropped.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset (acts regardless of ce)
//   ce         global clock enable; low freezes all state
//   in_valid   / in_ready   input handshake (in_ready == adv)
//   in_acc     signed accumulator value
//   in_scale   unsigned multiplier, travels with the beat
//   in_shift   unsigned right shift, travels with the beat
//   out_valid  / out_ready  output handshake
//   out_data   signed requantized value
//   out_sat    out_data was clamped
//   sat_cnt    saturating count of delivered clamped beats
//   sat_clr    synchronous clear of sat_cnt (wins over an increment)
//
// Optional feature: define REQUANT_RELU_EN to clamp the output to
// [0, 2^(OUT_WIDTH-1)-1]; negative results become 0 without flagging out_sat.
// -----------------------------------------------------------------------------
module linear_layer_requant_q #(
   parameter int ACC_WIDTH   = 38,
   parameter int SCALE_WIDTH = 16,
   parameter int SHIFT_WIDTH = 6,
   parameter int OUT_WIDTH   = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ce,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ACC_WIDTH-1:0]   in_acc,
   input  logic [SCALE_WIDTH-1:0] in_scale,
   input  logic [SHIFT_WIDTH-1:0] in_shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_sat,
   output logic [CNT_WIDTH-1:0]   sat_cnt,
   input  logic                   sat_clr
);

   localparam int PROD_W    = ACC_WIDTH + SCALE_WIDTH + 1;
   // One extra bit so adding the rounding constant can never overflow.
   localparam int RES_W     = PROD_W + 1;
   localparam int MAX_SHIFT = ACC_WIDTH + SCALE_WIDTH - 1;
   localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT_S = SHIFT_WIDTH'(MAX_SHIFT);

   localparam logic signed [RES_W-1:0] OUT_MAX =
      {{(RES_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [RES_W-1:0] OUT_MIN =
      {{(RES_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   // Pipeline state
   logic                          s1_valid_q, s1_valid_d;
   logic signed [PROD_W-1:0]      s1_prod_q, s1_prod_d;
   logic [SHIFT_WIDTH-1:0]        s1_shift_q, s1_shift_d;
   logic                          s2_valid_q, s2_valid_d;
   logic signed [RES_W-1:0]       s2_res_q, s2_res_d;
   logic                          out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
   logic                          out_sat_q, out_sat_d;
   logic [CNT_WIDTH-1:0]          sat_cnt_q, sat_cnt_d;

   logic                          adv;
   logic signed [PROD_W-1:0]      acc_ext, scale_ext;
   logic signed [RES_W-1:0]       prod_ext, rnd, sum;

   assign adv      = ce & (~out_valid_q | out_ready);
   assign in_ready = adv;

   // S1: full-precision product; scale is zero-extended so it stays positive.
   always_comb begin
      acc_ext    = {{(PROD_W-ACC_WIDTH){in_acc[ACC_WIDTH-1]}}, in_acc};
      scale_ext  = {{(PROD_W-SCALE_WIDTH){1'b0}}, in_scale};
      s1_valid_d = in_valid;
      s1_prod_d  = acc_ext * scale_ext;
      s1_shift_d = in_shift;
      if (32'(in_shift) > MAX_SHIFT) begin
         s1_shift_d = MAX_SHIFT_S;
      end
   end

   // S2: round half up, then arithmetic shift (floor), s == 0 passes through.
   always_comb begin
      prod_ext   = {s1_prod_q[PROD_W-1], s1_prod_q};
      rnd        = '0;
      if (s1_shift_q != '0) begin
         rnd = RES_W'(1) << (s1_shift_q - 1'b1);
      end
      sum        = prod_ext + rnd;
      s2_valid_d = s1_valid_q;
      s2_res_d   = sum >>> s1_shift_q;
   end

   // S3: clamp to the output range.
   always_comb begin
      out_valid_d = s2_valid_q;
      out_data_d  = s2_res_q[OUT_WIDTH-1:0];
      out_sat_d   = 1'b0;
      if (s2_res_q > OUT_MAX) begin
         out_data_d = OUT_MAX[OUT_WIDTH-1:0];
         out_sat_d  = 1'b1;
      end
`ifdef REQUANT_RELU_EN
      else if (s2_res_q < 0) begin
         // ReLU zeroing is a legitimate result, not a saturation event.
         out_data_d = '0;
         out_sat_d  = 1'b0;
      end
`else
      else if (s2_res_q < OUT_MIN) begin
         out_data_d = OUT_MIN[OUT_WIDTH-1:0];
         out_sat_d  = 1'b1;
      end
`endif
   end

   // Saturation counter: counts only real handshakes; frozen while ce is low
   // because the output beat is not consumed in that case.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (ce) begin
         if (sat_clr) begin
            sat_cnt_d = '0;
         end else if (out_valid_q & out_ready & out_sat_q & ~(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
         end
      end
   end

   // Control state: valid bits, output register and counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         sat_cnt_q   <= '0;
      end else begin
         if (adv) begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
         end
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Datapath registers need no reset: their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_prod_q  <= s1_prod_d;
         s1_shift_q <= s1_shift_d;
         s2_res_q   <= s2_res_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_linear_layer_requant_q.sv
module tb_linear_layer_requant_q;

   localparam int AW = 38;
   localparam int SW = 16;
   localparam int HW = 6;
   localparam int OW = 4;
   localparam int CW = 16;

`ifdef REQUANT_RELU_EN
   localparam logic [OW-1:0] E_N2000_D = 4'h0;
   localparam logic          E_N2000_S = 1'b0;
   localparam logic [OW-1:0] E_TIE_D   = 4'h0;
`else
   localparam logic [OW-1:0] E_N2000_D = 4'h8;
   localparam logic          E_N2000_S = 1'b1;
   localparam logic [OW-1:0] E_TIE_D   = 4'hF;
`endif

   logic          clk = 1'b0;
   logic          reset, ce, in_valid, in_ready;
   logic [AW-1:0] in_acc;
   logic [SW-1:0] in_scale;
   logic [HW-1:0] in_shift;
   logic          out_valid, out_ready, out_sat, sat_clr;
   logic [OW-1:0] out_data;
   logic [CW-1:0] sat_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 clk = ~clk;

   linear_layer_requant_q #(
      .ACC_WIDTH(AW), .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW),
      .OUT_WIDTH(OW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_acc(in_acc), .in_scale(in_scale), .in_shift(in_shift),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat),
      .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat, measure latency from the accepting edge, check the
   // result, then let it be consumed (optionally with sat_clr that cycle).
   task automatic single(input string tag, input logic [AW-1:0] acc,
                         input logic [SW-1:0] scale, input logic [HW-1:0] shift,
                         input logic [OW-1:0] exp_d, input logic exp_s,
                         input logic clr_at_out);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_acc    = acc;
      in_scale  = scale;
      in_shift  = shift;
      check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'd3);
      check_eq({tag, "_data"}, 64'(out_data), 64'(exp_d));
      check_eq({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
      sat_clr = clr_at_out;
      tick();
      sat_clr = 1'b0;
      if (clr_at_out) exp_cnt = 0;
      else if (exp_s) exp_cnt++;
      check_eq({tag, "_cnt"}, 64'(sat_cnt), 64'(exp_cnt));
      check_eq({tag, "_done"}, 64'(out_valid), 64'd0);
   endtask

   logic [AW-1:0] st_acc [4];
   logic [OW-1:0] st_exp [4];

   initial begin
      int idx, rx;
      logic [OW-1:0] held;
      logic held_v, took, stale;

      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_acc = '0; in_scale = '0;
      in_shift = '0; out_ready = 1'b1; sat_clr = 1'b0;
      tick();
      tick();
      check_eq("rst_ov", 64'(out_valid), 64'd0);
      check_eq("rst_data", 64'(out_data), 64'd0);
      check_eq("rst_sat", 64'(out_sat), 64'd0);
      check_eq("rst_cnt", 64'(sat_cnt), 64'd0);
      reset = 1'b0;
      check_eq("post_rst_rdy", 64'(in_ready), 64'd1);

      // Basic, saturating, tie-rounding and shift-boundary beats
      single("t100x3s6",   38'd100,          16'd1 * 3, 6'd4 + 2, 4'd5,      1'b0,      1'b0);
      single("t1000s4",    38'd1000,         16'd1,     6'd4,     4'd7,      1'b1,      1'b0);
      single("tn2000s4",   -38'sd2000,       16'd1,     6'd4,     E_N2000_D, E_N2000_S, 1'b0);
      single("tn24tie",    -38'sd24,         16'd1,     6'd4,     E_TIE_D,   1'b0,      1'b0);
      single("t7s0",       38'd7,            16'd1,     6'd0,     4'd7,      1'b0,      1'b0);
      single("t5s63",      38'd5,            16'd1,     6'd63,    4'd0,      1'b0,      1'b0);
      single("t1000x300",  38'd1000,         16'd300,   6'd8,     4'd7,      1'b1,      1'b0);
      // Clear coincides with a saturating handshake: clear wins
      single("tclrprio",   38'd1000,         16'd1,     6'd4,     4'd7,      1'b1,      1'b1);

      // Four back-to-back beats with the output stalled for 5 cycles
      st_acc[0] = 38'd16; st_acc[1] = 38'd32; st_acc[2] = 38'd48; st_acc[3] = 38'd80;
      st_exp[0] = 4'd1;   st_exp[1] = 4'd2;   st_exp[2] = 4'd3;   st_exp[3] = 4'd5;
      idx = 0; rx = 0; held = '0; held_v = 1'b0;
      for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
         out_ready = (cyc >= 5);
         if (idx < 4) begin
            in_valid = 1'b1; in_acc = st_acc[idx]; in_scale = 16'd1; in_shift = 6'd4;
         end else begin
            in_valid = 1'b0;
         end
         if (cyc < 5 && out_valid) begin
            check_eq("stall_rdy", 64'(in_ready), 64'd0);
            if (held_v) check_eq("stall_hold", 64'(out_data), 64'(held));
            held = out_data;
            held_v = 1'b1;
         end
         if (out_valid && out_ready) begin
            check_eq($sformatf("stall_ord%0d", rx), 64'(out_data), 64'(st_exp[rx]));
            rx++;
         end
         took = in_valid && in_ready;
         tick();
         if (took) idx++;
      end
      in_valid = 1'b0;
      check_eq("stall_all", 64'(rx), 64'd4);
      check_eq("stall_cnt", 64'(sat_cnt), 64'(exp_cnt));

      // Reset with three saturating beats in flight
      out_ready = 1'b1;
      in_valid = 1'b1; in_acc = 38'd1000; in_scale = 16'd1; in_shift = 6'd4;
      tick(); tick(); tick();
      in_valid = 1'b0;
      check_eq("mid_pre_ov", 64'(out_valid), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = 0;
      check_eq("mid_rst_ov", 64'(out_valid), 64'd0);
      check_eq("mid_rst_cnt", 64'(sat_cnt), 64'd0);
      stale = 1'b0;
      repeat (6) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      check_eq("mid_no_stale", 64'(stale), 64'd0);
      check_eq("mid_end_cnt", 64'(sat_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
